// File: rtl/fir_pkg.sv
// Shared width defaults and rounding/saturation helpers for the FIR output stage.
package fir_pkg;
    localparam int IW_DEF    = 16;
    localparam int TW_DEF    = 16;
    localparam int AW_DEF    = IW_DEF + TW_DEF + 8;
    localparam int OW_DEF    = 16;
    localparam int SHIFT_DEF = 15;
    localparam int DEPTH_DEF = 4;

    // Round half-up then drop sh fractional bits; 64-bit math keeps the add from wrapping.
    function automatic logic signed [63:0] rnd_shr(input logic signed [63:0] v, input int unsigned sh);
        return (v + (64'sd1 <<< (sh - 1))) >>> sh;
    endfunction

    function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int unsigned ow);
        logic signed [63:0] hi, lo;
        hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (ow - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction
endpackage

// File: rtl/fir_out_fifo.sv
// Show-ahead output FIFO with occupancy count; head data reads as zero when empty.
module fir_out_fifo #(
    parameter int OW    = 16,
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  logic [OW-1:0]            i_data,
    input  logic                     i_pop,
    output logic [OW-1:0]            o_data,
    output logic                     o_valid,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [OW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_q, rd_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          wr_en, rd_en;

    assign o_empty = (cnt_q == '0);
    assign o_full  = (cnt_q == CW'(DEPTH));
    assign rd_en   = i_pop & ~o_empty;
    // When full, a simultaneous pop frees the head slot, which is exactly where wr_q points.
    assign wr_en   = i_push & (~o_full | rd_en);

    always_comb begin
        cnt_d = cnt_q;
        case ({wr_en, rd_en})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (wr_en) wr_q <= wr_q + PW'(1);
            if (rd_en) rd_q <= rd_q + PW'(1);
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (wr_en) mem_q[wr_q] <= i_data;
    end

    assign o_valid = ~o_empty;
    assign o_count = cnt_q;
    assign o_data  = o_empty ? '0 : mem_q[rd_q];
endmodule

// File: rtl/fir_out_stage.sv
// FIR output stage: round, saturate, and buffer tap-chain results for a ready/valid consumer.
module fir_out_stage
    import fir_pkg::*;
#(
    parameter int IW    = IW_DEF,
    parameter int TW    = TW_DEF,
    parameter int AW    = IW + TW + 8,
    parameter int OW    = OW_DEF,
    parameter int SHIFT = SHIFT_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic signed [AW-1:0]     i_acc,
    input  logic                     i_valid,
    output logic signed [OW-1:0]     o_data,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_overflow,
    input  logic                     i_clr_ovf,
    output logic                     o_drop
);
    logic signed [AW:0]  s1_q, s1_d;
    logic                s1_vld_q;
    logic signed [63:0]  s1_rnd, s1_ext, s2_sat;
    logic                s2_clip, pop, fifo_full, fifo_empty;
    logic                ovf_q, ovf_d, drop_q, drop_d;
    logic                unused_hi;

    assign s1_rnd    = rnd_shr(64'(i_acc), SHIFT);
    assign s1_d      = s1_rnd[AW:0];
    assign unused_hi = ^s1_rnd[63:AW+1];

    assign s1_ext  = 64'(s1_q);
    assign s2_sat  = sat(s1_ext, OW);
    assign s2_clip = (s2_sat != s1_ext);

    assign pop    = i_ready & ~fifo_empty;
    assign drop_d = s1_vld_q & fifo_full & ~pop;
    // A clip on a dropped result still counts; a clip wins over a same-edge clear.
    assign ovf_d  = (ovf_q & ~i_clr_ovf) | (s1_vld_q & s2_clip);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_q     <= '0;
            s1_vld_q <= 1'b0;
            ovf_q    <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            s1_vld_q <= i_valid;
            if (i_valid) s1_q <= s1_d;
            ovf_q    <= ovf_d;
            drop_q   <= drop_d;
        end
    end

    fir_out_fifo #(.OW(OW), .DEPTH(DEPTH)) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (s1_vld_q),
        .i_data  (s2_sat[OW-1:0]),
        .i_pop   (pop),
        .o_data  (o_data),
        .o_valid (o_valid),
        .o_count (o_count),
        .o_full  (fifo_full),
        .o_empty (fifo_empty)
    );

    assign o_overflow = ovf_q;
    assign o_drop     = drop_q;
endmodule

// File: tb/tb_fir_out_stage.sv
// Self-checking bench: queue-level reference model plus negedge monitor, directed cases then random traffic.
module tb_fir_out_stage;
    localparam int AW = 40, OW = 16, SHIFT = 15, DEPTH = 4;

    logic                 i_clk = 1'b0, i_rst_n = 1'b0;
    logic signed [AW-1:0] i_acc = '0;
    logic                 i_valid = 1'b0, i_ready = 1'b0, i_clr_ovf = 1'b0;
    logic signed [OW-1:0] o_data;
    logic                 o_valid, o_overflow, o_drop;
    logic [$clog2(DEPTH):0] o_count;

    fir_out_stage #(.IW(16), .TW(16), .AW(AW), .OW(OW), .SHIFT(SHIFT), .DEPTH(DEPTH)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_acc(i_acc), .i_valid(i_valid),
        .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready), .o_count(o_count),
        .o_overflow(o_overflow), .i_clr_ovf(i_clr_ovf), .o_drop(o_drop)
    );

    always #5 i_clk = ~i_clk;

    int nchk = 0, nerr = 0, drops_seen = 0;

    task automatic chk(string nm, longint act, longint exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: floor((a + 2^(S-1)) / 2^S), then clamp to the OW-bit signed range.
    function automatic longint ref_round(longint a);
        longint d, num, q;
        d   = longint'(1) << SHIFT;
        num = a + d / 2;
        q   = num / d;
        if ((num % d) != 0 && num < 0) q = q - 1;
        return q;
    endfunction

    function automatic longint ref_clip(longint v, output bit c);
        longint lim;
        lim = longint'(1) << (OW - 1);
        c = 1'b1;
        if (v > lim - 1) return lim - 1;
        if (v < -lim) return -lim;
        c = 1'b0;
        return v;
    endfunction

    longint mq[$];
    bit     m_s1v = 1'b0, m_drop = 1'b0, m_ovf = 1'b0;
    longint m_s1 = 0;
    bit     pop_m, full_m, clip_m;
    longint v_m, tmp_m;

    always @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mq.delete();
            m_s1v  = 1'b0;
            m_drop = 1'b0;
            m_ovf  = 1'b0;
        end else begin
            pop_m  = (mq.size() > 0) && i_ready;
            full_m = (mq.size() == DEPTH);
            if (pop_m) tmp_m = mq.pop_front();
            m_drop = 1'b0;
            if (i_clr_ovf) m_ovf = 1'b0;
            if (m_s1v) begin
                v_m = ref_clip(m_s1, clip_m);
                if (clip_m) m_ovf = 1'b1;
                if (full_m && !pop_m) m_drop = 1'b1;
                else mq.push_back(v_m);
            end
            m_s1v = i_valid;
            if (i_valid) m_s1 = ref_round(longint'(i_acc));
        end
    end

    always @(negedge i_clk) begin
        if (i_rst_n) begin
            chk("valid", longint'(o_valid), longint'(mq.size() > 0));
            chk("count", longint'(o_count), longint'(mq.size()));
            chk("drop", longint'(o_drop), longint'(m_drop));
            chk("ovf", longint'(o_overflow), longint'(m_ovf));
            if (o_valid && mq.size() > 0) chk("data", longint'(o_data), mq[0]);
            if (o_drop) drops_seen++;
        end
    end

    task automatic cyc();
        @(posedge i_clk);
        #1;
    endtask

    task automatic send(longint a);
        i_valid = 1'b1;
        i_acc   = a[AW-1:0];
        cyc();
        i_valid = 1'b0;
    endtask

    task automatic one_shot(string nm, longint a, longint exp);
        send(a);
        cyc();
        @(negedge i_clk);
        chk({nm, "_valid"}, longint'(o_valid), 1);
        chk({nm, "_data"}, longint'(o_data), exp);
    endtask

    longint x;

    initial begin
        repeat (2) cyc();
        @(negedge i_clk);
        chk("rst_valid", longint'(o_valid), 0);
        chk("rst_count", longint'(o_count), 0);
        chk("rst_data", longint'(o_data), 0);
        chk("rst_ovf", longint'(o_overflow), 0);
        chk("rst_drop", longint'(o_drop), 0);
        cyc();
        i_rst_n = 1'b1;
        cyc();

        i_ready = 1'b1;
        one_shot("lat2", 49152, 2);
        chk("lat2_ovf", longint'(o_overflow), 0);
        cyc();
        one_shot("neg_half", -16384, 0);
        cyc();
        one_shot("neg_half_m1", -16385, -1);
        cyc();
        one_shot("sat_hi", longint'(1) << 30, 32767);
        chk("sat_hi_ovf", longint'(o_overflow), 1);
        cyc();
        one_shot("sat_lo", -(longint'(1) << 31), -32768);
        cyc();
        i_clr_ovf = 1'b1;
        cyc();
        i_clr_ovf = 1'b0;
        @(negedge i_clk);
        chk("clr_ovf", longint'(o_overflow), 0);
        cyc();

        // Fill past capacity with the consumer stalled.
        i_ready = 1'b0;
        drops_seen = 0;
        for (int k = 1; k <= 6; k++) begin
            i_valid = 1'b1;
            i_acc   = AW'(k * 32768);
            cyc();
        end
        i_valid = 1'b0;
        cyc();
        cyc();
        @(negedge i_clk);
        chk("full_count", longint'(o_count), 4);
        chk("full_drops", longint'(drops_seen), 2);
        chk("drain_1", longint'(o_data), 1);
        i_ready = 1'b1;
        for (int k = 2; k <= 4; k++) begin
            @(negedge i_clk);
            chk("drain_k", longint'(o_data), longint'(k));
        end
        repeat (3) cyc();

        // Full FIFO with same-edge push and pop across pointer wrap.
        i_ready = 1'b0;
        drops_seen = 0;
        for (int k = 0; k < 10; k++) begin
            i_valid = 1'b1;
            i_acc   = AW'((10 + k) * 32768);
            if (k == 5) i_ready = 1'b1;
            cyc();
        end
        i_valid = 1'b0;
        @(negedge i_clk);
        chk("pp_count", longint'(o_count), 4);
        chk("pp_drops", longint'(drops_seen), 0);
        repeat (8) cyc();

        // Reset with buffered and in-flight results.
        i_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            i_valid = 1'b1;
            i_acc   = AW'(k * 65536);
            cyc();
        end
        i_acc   = AW'(5 * 65536);
        i_rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", longint'(o_valid), 0);
        chk("mid_rst_count", longint'(o_count), 0);
        cyc();
        i_valid = 1'b0;
        i_ready = 1'b1;
        cyc();
        i_rst_n = 1'b1;
        repeat (5) cyc();
        @(negedge i_clk);
        chk("post_rst_idle", longint'(o_valid), 0);

        for (int n = 0; n < 400; n++) begin
            i_valid   = ($urandom_range(0, 3) != 0);
            i_ready   = ($urandom_range(0, 9) < 6);
            i_clr_ovf = ($urandom_range(0, 19) == 0);
            case ($urandom_range(0, 3))
                0: x = longint'($urandom_range(0, 1 << 21)) - (longint'(1) << 20);
                1: x = longint'(signed'($urandom()));
                2: x = {$urandom(), $urandom()};
                default: x = longint'($urandom_range(0, 200)) * 32768 - 16384 * 201
                             + longint'($urandom_range(0, 2)) - 1;
            endcase
            i_acc = x[AW-1:0];
            cyc();
        end
        i_valid   = 1'b0;
        i_clr_ovf = 1'b0;
        i_ready   = 1'b1;
        repeat (8) cyc();
        @(negedge i_clk);
        chk("final_empty", longint'(o_count), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
        $finish;
    end
endmodule

// File: doc/fir_out_stage.md
FIR_OUT_STAGE -- requirements
Module: fir_out_stage

Interface
REQ-001 The block SHALL have parameter IW, default 16, sample width of the tap chain.
REQ-002 The block SHALL have parameter TW, default 16, tap width.
REQ-003 The block SHALL have parameter AW, default IW+TW+8, width of the incoming accumulator.
REQ-004 The block SHALL have parameter OW, default 16, output sample width.
REQ-005 The block SHALL have parameter SHIFT, default 15, number of fractional bits dropped (SHIFT>=1).
REQ-006 The block SHALL have parameter DEPTH, default 4, output FIFO depth (power of two, >=2).
REQ-007 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-008 i_clk  input  1  sole clock; all state updates on rising edge.
REQ-009 i_rst_n  input  1  asynchronous active-low reset.
REQ-010 i_acc  input  AW  signed accumulator result from the last tap of the chain.
REQ-011 i_valid  input  1  i_acc is a new result this cycle.
REQ-012 o_data  output  OW  signed, rounded, saturated result at FIFO head.
REQ-013 o_valid  output  1  o_data holds a valid entry.
REQ-014 i_ready  input  1  consumer accepts o_data this cycle.
REQ-015 o_count  output  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-016 o_overflow  output  1  sticky flag: at least one result saturated.
REQ-017 i_clr_ovf  input  1  synchronous clear of o_overflow.
REQ-018 o_drop  output  1  one-cycle pulse: a result was lost because the FIFO was full.

Function
REQ-019 Stage 1: on an edge with i_valid=1, the block SHALL register (i_acc + 2^(SHIFT-1)) arithmetically shifted right by SHIFT, computed at AW+1 bits so the rounding add never wraps.
REQ-020 Rounding SHALL be round-half-up (toward +infinity on exact halves).
REQ-021 Stage 2: the stage-1 value SHALL be saturated to [-2^(OW-1), 2^(OW-1)-1] and pushed into the FIFO one edge after stage 1.
REQ-022 Result latency SHALL be 2 cycles: i_valid sampled at edge E0 -> entry in FIFO and o_valid=1 after edge E1; no bypass when empty.
REQ-023 Stage-1/stage-2 valid bits SHALL form a 2-deep pipeline that never stalls; i_valid may be high every cycle.
REQ-024 A pop SHALL occur on an edge where o_valid=1 and i_ready=1; o_data SHALL then advance to the next entry or o_valid falls.
REQ-025 i_ready while o_valid=0 SHALL have no effect.
REQ-026 Push and pop on the same edge SHALL both occur, count unchanged, including when full (no drop).
REQ-027 Push while full with no pop SHALL discard the new result, leave FIFO contents and o_count unchanged, and pulse o_drop high for the following cycle.
REQ-028 o_data SHALL remain stable while o_valid=1 and i_ready=0.
REQ-029 o_overflow SHALL set after any edge where stage 2 clips a value, including a value later dropped.
REQ-030 o_overflow SHALL clear on an edge with i_clr_ovf=1; simultaneous clip and clear SHALL leave it set.
REQ-031 FIFO read/write pointers SHALL wrap modulo DEPTH; o_count SHALL range 0..DEPTH.

Reset
REQ-032 While i_rst_n=0: o_valid=0, o_count=0, o_overflow=0, o_drop=0, o_data=0, pipeline valids=0, pointers=0.
REQ-033 Reset assertion mid-stream SHALL discard in-flight and buffered results immediately; no pop/push after release until new i_valid.

Structure
REQ-034 Default width constants and the round/saturate helper function SHALL live in shared package fir_pkg.
REQ-035 The FIFO SHALL be one sub-module, fir_out_fifo (show-ahead, parameters OW, DEPTH, with count and full/empty).

Verification
REQ-036 i_acc=49152, i_valid one cycle, i_ready=1 -> o_valid after 2 edges with o_data=2, o_overflow=0.
REQ-037 i_acc=-16384 -> o_data=0; i_acc=-16385 -> o_data=-1 (half-up rounding at negative boundary).
REQ-038 i_acc=2^30 -> o_data=32767, o_overflow=1; i_acc=-2^31 -> o_data=-32768; then i_clr_ovf=1 -> o_overflow=0.
REQ-039 i_ready=0, six back-to-back i_valid with values 1..6 x2^15 -> o_count=4, data 1..4 retained, o_drop pulses twice, then draining yields 1,2,3,4.
REQ-040 FIFO full plus i_valid plus i_ready same edge -> no o_drop, o_count stays 4, order preserved across pointer wrap.
REQ-041 Assert i_rst_n=0 with 3 entries and 2 in flight -> o_valid=0, o_count=0 immediately; after release no output until new i_valid.
